// File: rtl/reg_op_sequencer.sv
// ---------------------------------------------------------------------------
// reg_op_sequencer
//
// Purpose:
//   Two-requester command sequencer that owns the control inputs of one
//   shared multi-function register (clear / load / inc / dec / shift right /
//   shift left). Commands arrive through a valid/ready handshake. Requesters
//   are arbitrated round-robin. Each accepted command is expanded into a
//   burst of single-cycle strobes on the register.
//
// Handshake:
//   reqN_ready is high only in IDLE, and only for the granted requester.
//   A command transfers on a rising edge where reqN_valid && reqN_ready.
//   A requester keeps valid and its fields stable until it sees ready.
//
// Ports:
//   clk, rst_n                  clock (rising edge), async active-low reset
//   reqN_valid / reqN_ready     command handshake, N = 0, 1
//   reqN_op                     0 NOP, 1 CLR, 2 LOAD, 3 INC, 4 DEC, 5 SHR,
//                               6 SHL, 7 reserved (treated as NOP)
//   reqN_cnt                    repeat count for INC/DEC/SHR/SHL
//   reqN_data                   load value for LOAD
//   reqN_fill                   serial fill bit for SHR/SHL
//   reg_cl/ld/inc/dec/sr/sl     one-hot register control strobes
//   reg_in                      load data, held for the whole command
//   reg_ir/reg_il               shift fill bits, held for the whole command
//   busy                        high in EXEC and DONE
//   done / done_id              one-cycle completion pulse and requester id
//   dbg_state                   current FSM state (0 IDLE, 1 EXEC, 2 DONE)
// ---------------------------------------------------------------------------
module reg_op_sequencer #(
    parameter int DATA_WIDTH = 16,
    parameter int CNT_WIDTH  = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,

    input  logic                  req0_valid,
    output logic                  req0_ready,
    input  logic [2:0]            req0_op,
    input  logic [CNT_WIDTH-1:0]  req0_cnt,
    input  logic [DATA_WIDTH-1:0] req0_data,
    input  logic                  req0_fill,

    input  logic                  req1_valid,
    output logic                  req1_ready,
    input  logic [2:0]            req1_op,
    input  logic [CNT_WIDTH-1:0]  req1_cnt,
    input  logic [DATA_WIDTH-1:0] req1_data,
    input  logic                  req1_fill,

    output logic                  reg_cl,
    output logic                  reg_ld,
    output logic [DATA_WIDTH-1:0] reg_in,
    output logic                  reg_inc,
    output logic                  reg_dec,
    output logic                  reg_sr,
    output logic                  reg_ir,
    output logic                  reg_sl,
    output logic                  reg_il,
    output logic                  busy,
    output logic                  done,
    output logic                  done_id,
    output logic [1:0]            dbg_state
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_EXEC = 2'd1,
        S_DONE = 2'd2
    } state_t;

    localparam logic [2:0] OP_CLR  = 3'd1;
    localparam logic [2:0] OP_LOAD = 3'd2;
    localparam logic [2:0] OP_INC  = 3'd3;
    localparam logic [2:0] OP_DEC  = 3'd4;
    localparam logic [2:0] OP_SHR  = 3'd5;
    localparam logic [2:0] OP_SHL  = 3'd6;

    state_t                r_state;
    logic                  r_last_grant;
    logic [2:0]            r_op;
    logic [CNT_WIDTH-1:0]  r_cnt;
    logic [DATA_WIDTH-1:0] r_data;
    logic                  r_fill;
    logic                  r_id;

    state_t                w_next_state;
    logic                  w_accept;
    logic                  w_grant_id;
    logic                  w_step;
    logic [2:0]            w_sel_op;
    logic [CNT_WIDTH-1:0]  w_sel_cnt;
    logic [DATA_WIDTH-1:0] w_sel_data;
    logic                  w_sel_fill;

    // Next-state, handshake and strobe decode.
    always_comb begin
        w_next_state = r_state;
        w_accept     = 1'b0;
        w_grant_id   = 1'b0;
        w_step       = 1'b0;
        req0_ready   = 1'b0;
        req1_ready   = 1'b0;
        reg_cl       = 1'b0;
        reg_ld       = 1'b0;
        reg_inc      = 1'b0;
        reg_dec      = 1'b0;
        reg_sr       = 1'b0;
        reg_sl       = 1'b0;
        reg_in       = '0;
        reg_ir       = 1'b0;
        reg_il       = 1'b0;
        busy         = 1'b0;
        done         = 1'b0;
        done_id      = 1'b0;

        case (r_state)
            S_IDLE: begin
                // req0 wins when alone, or when req1 was granted last.
                if (req0_valid && (!req1_valid || r_last_grant)) begin
                    req0_ready   = 1'b1;
                    w_accept     = 1'b1;
                    w_grant_id   = 1'b0;
                    w_next_state = S_EXEC;
                end else if (req1_valid) begin
                    req1_ready   = 1'b1;
                    w_accept     = 1'b1;
                    w_grant_id   = 1'b1;
                    w_next_state = S_EXEC;
                end
            end

            S_EXEC: begin
                busy   = 1'b1;
                reg_in = r_data;
                reg_ir = r_fill;
                reg_il = r_fill;
                // Default exit covers single-cycle ops, NOP, op 7 and cnt=0.
                w_next_state = S_DONE;
                case (r_op)
                    OP_CLR:  reg_cl = 1'b1;
                    OP_LOAD: reg_ld = 1'b1;
                    OP_INC, OP_DEC, OP_SHR, OP_SHL: begin
                        if (r_cnt != '0) begin
                            w_step  = 1'b1;
                            reg_inc = (r_op == OP_INC);
                            reg_dec = (r_op == OP_DEC);
                            reg_sr  = (r_op == OP_SHR);
                            reg_sl  = (r_op == OP_SHL);
                            // Stay until the strobe for the last step.
                            if (r_cnt != CNT_WIDTH'(1)) begin
                                w_next_state = S_EXEC;
                            end
                        end
                    end
                    default: ;
                endcase
            end

            S_DONE: begin
                busy         = 1'b1;
                reg_in       = r_data;
                reg_ir       = r_fill;
                reg_il       = r_fill;
                done         = 1'b1;
                done_id      = r_id;
                w_next_state = S_IDLE;
            end

            default: w_next_state = S_IDLE;
        endcase
    end

    // Field mux for the granted requester.
    always_comb begin
        w_sel_op   = w_grant_id ? req1_op   : req0_op;
        w_sel_cnt  = w_grant_id ? req1_cnt  : req0_cnt;
        w_sel_data = w_grant_id ? req1_data : req0_data;
        w_sel_fill = w_grant_id ? req1_fill : req0_fill;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= S_IDLE;
            r_last_grant <= 1'b1;
            r_op         <= '0;
            r_cnt        <= '0;
            r_data       <= '0;
            r_fill       <= 1'b0;
            r_id         <= 1'b0;
        end else begin
            r_state <= w_next_state;
            if (w_accept) begin
                r_op         <= w_sel_op;
                r_cnt        <= w_sel_cnt;
                r_data       <= w_sel_data;
                r_fill       <= w_sel_fill;
                r_id         <= w_grant_id;
                r_last_grant <= w_grant_id;
            end else if (w_step) begin
                r_cnt <= r_cnt - CNT_WIDTH'(1);
            end
        end
    end

    assign dbg_state = r_state;

endmodule

// File: tb/tb_reg_op_sequencer.sv
// ---------------------------------------------------------------------------
// tb_reg_op_sequencer
//
// Directed and randomized checks of reg_op_sequencer. A behavioural register
// sits on the strobe outputs; the expected register value after each command
// is computed from the command itself with plain arithmetic.
// ---------------------------------------------------------------------------
module tb_reg_op_sequencer;

  localparam int DW = 16;
  localparam int CW = 4;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          req0_valid = 1'b0, req1_valid = 1'b0;
  logic          req0_ready, req1_ready;
  logic [2:0]    req0_op = '0, req1_op = '0;
  logic [CW-1:0] req0_cnt = '0, req1_cnt = '0;
  logic [DW-1:0] req0_data = '0, req1_data = '0;
  logic          req0_fill = 1'b0, req1_fill = 1'b0;
  logic          reg_cl, reg_ld, reg_inc, reg_dec, reg_sr, reg_ir, reg_sl, reg_il;
  logic [DW-1:0] reg_in;
  logic          busy, done, done_id;
  logic [1:0]    dbg_state;

  int n_assert = 0;
  int n_fail = 0;

  logic [DW-1:0] plant = '0;
  logic [5:0]    sv;
  assign sv = {reg_cl, reg_ld, reg_inc, reg_dec, reg_sr, reg_sl};

  reg_op_sequencer #(.DATA_WIDTH(DW), .CNT_WIDTH(CW)) dut (
    .clk(clk), .rst_n(rst_n),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_op(req0_op),
    .req0_cnt(req0_cnt), .req0_data(req0_data), .req0_fill(req0_fill),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_op(req1_op),
    .req1_cnt(req1_cnt), .req1_data(req1_data), .req1_fill(req1_fill),
    .reg_cl(reg_cl), .reg_ld(reg_ld), .reg_in(reg_in), .reg_inc(reg_inc),
    .reg_dec(reg_dec), .reg_sr(reg_sr), .reg_ir(reg_ir), .reg_sl(reg_sl),
    .reg_il(reg_il), .busy(busy), .done(done), .done_id(done_id),
    .dbg_state(dbg_state)
  );

  // ---------------- clock ----------------
  always #5 clk = ~clk;

  // The register being controlled: reacts to strobes on the rising edge.
  always @(posedge clk) begin
    if (reg_cl)       plant <= '0;
    else if (reg_ld)  plant <= reg_in;
    else if (reg_inc) plant <= plant + 16'd1;
    else if (reg_dec) plant <= plant - 16'd1;
    else if (reg_sr)  plant <= {reg_ir, plant[DW-1:1]};
    else if (reg_sl)  plant <= {plant[DW-2:0], reg_il};
  end

  // ---------------- reference model ----------------
  function automatic logic [DW-1:0] ref_apply(input logic [2:0] op, input int cnt,
                                              input logic [DW-1:0] data, input logic fill,
                                              input logic [DW-1:0] v);
    logic [DW-1:0] r;
    r = v;
    case (op)
      3'd1: r = '0;
      3'd2: r = data;
      3'd3: r = DW'(int'(v) + cnt);
      3'd4: r = DW'(int'(v) - cnt);
      3'd5: for (int i = 0; i < cnt; i++) r = {fill, r[DW-1:1]};
      3'd6: for (int i = 0; i < cnt; i++) r = {r[DW-2:0], fill};
      default: r = v;
    endcase
    return r;
  endfunction

  function automatic int ref_strobes(input logic [2:0] op, input int cnt);
    if (op == 3'd1 || op == 3'd2) return 1;
    if (op >= 3'd3 && op <= 3'd6) return cnt;
    return 0;
  endfunction

  function automatic logic [5:0] ref_vec(input logic [2:0] op);
    case (op)
      3'd1: return 6'b100000;
      3'd2: return 6'b010000;
      3'd3: return 6'b001000;
      3'd4: return 6'b000100;
      3'd5: return 6'b000010;
      3'd6: return 6'b000001;
      default: return 6'b000000;
    endcase
  endfunction

  // ---------------- checking ----------------
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // ---------------- drivers ----------------
  task automatic set_req(input int id, input logic v, input logic [2:0] op, input logic [CW-1:0] cnt,
                         input logic [DW-1:0] data, input logic fill);
    if (id == 0) begin
      req0_valid = v; req0_op = op; req0_cnt = cnt; req0_data = data; req0_fill = fill;
    end else begin
      req1_valid = v; req1_op = op; req1_cnt = cnt; req1_data = data; req1_fill = fill;
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    @(negedge clk);
    check("rst_strobes", {26'd0, sv}, 0);
    check("rst_reg_in", {16'd0, reg_in}, 0);
    check("rst_misc", {27'd0, reg_ir, reg_il, busy, done, done_id}, 0);
    rst_n = 1'b1;
  endtask

  // Issue one command from requester id and check it cycle by cycle.
  task automatic run_cmd(input int id, input logic [2:0] op, input logic [CW-1:0] cnt,
                         input logic [DW-1:0] data, input logic fill);
    int n_str, n_cyc, waited;
    logic got;
    logic [DW-1:0] exp_val;
    n_str = ref_strobes(op, int'(cnt));
    n_cyc = (n_str == 0) ? 1 : n_str;
    @(negedge clk);
    exp_val = ref_apply(op, int'(cnt), data, fill, plant);
    set_req(id, 1'b1, op, cnt, data, fill);
    #1;
    waited = 0;
    got = (id == 0) ? req0_ready : req1_ready;
    while (!got && waited < 50) begin
      @(negedge clk); #1;
      waited++;
      got = (id == 0) ? req0_ready : req1_ready;
    end
    check("accept", {31'd0, got}, 1);
    if (!got) begin
      set_req(id, 1'b0, op, cnt, data, fill);
      return;
    end
    check("ready_other", {31'd0, (id == 0) ? req1_ready : req0_ready}, 0);
    check("busy_at_accept", {31'd0, busy}, 0);
    @(posedge clk); #1;
    set_req(id, 1'b0, op, cnt, data, fill);
    for (int k = 1; k <= n_cyc + 1; k++) begin
      @(negedge clk);
      check("strobes", {26'd0, sv}, (k <= n_str) ? {26'd0, ref_vec(op)} : 0);
      check("done", {31'd0, done}, (k == n_cyc + 1) ? 1 : 0);
      if (k == n_cyc + 1) check("done_id", {31'd0, done_id}, id);
      check("busy", {31'd0, busy}, 1);
      check("reg_in", {16'd0, reg_in}, {16'd0, data});
      check("fill", {30'd0, reg_ir, reg_il}, {30'd0, fill, fill});
    end
    @(negedge clk);
    check("idle_busy_done", {30'd0, busy, done}, 0);
    check("idle_datapath", {14'd0, reg_in, reg_ir, reg_il}, 0);
    check("reg_value", {16'd0, plant}, {16'd0, exp_val});
  endtask

  // ---------------- stimulus ----------------
  int got_q[$];
  int exp_q[$];

  initial begin
    // Test 1: reset and LOAD
    do_reset();
    run_cmd(0, 3'd2, 4'd0, 16'h1234, 1'b0);
    check("t1_value", {16'd0, plant}, 32'h1234);

    // Test 2: INC x5 from req1
    run_cmd(1, 3'd3, 4'd5, 16'h0000, 1'b0);
    check("t2_value", {16'd0, plant}, 32'h1239);

    // Test 3: both requesters valid continuously after reset
    do_reset();
    @(negedge clk);
    set_req(0, 1'b1, 3'd1, 4'd0, 16'h0, 1'b0);
    set_req(1, 1'b1, 3'd3, 4'd2, 16'h0, 1'b0);
    exp_q = '{0, 1, 0, 1};
    got_q.delete();
    for (int c = 0; c < 100 && got_q.size() < 4; c++) begin
      #1;
      check("t3_ready_excl", {31'd0, req0_ready & req1_ready}, 0);
      check("t3_onehot", {31'd0, $countones(sv) <= 1}, 1);
      if (req0_ready) got_q.push_back(0);
      if (req1_ready) got_q.push_back(1);
      if (got_q.size() == 4) begin
        @(posedge clk); #1;
        req0_valid = 1'b0;
        req1_valid = 1'b0;
      end else begin
        @(negedge clk);
      end
    end
    check("t3_grant_count", got_q.size(), 4);
    for (int i = 0; i < got_q.size() && i < 4; i++) check("t3_grant", got_q[i], exp_q[i]);
    repeat (6) @(negedge clk);
    check("t3_value", {16'd0, plant}, 32'h0002);

    // Test 4: SHL with fill, SHR cnt=0
    run_cmd(0, 3'd2, 4'd0, 16'h0001, 1'b0);
    run_cmd(1, 3'd6, 4'd3, 16'h0000, 1'b1);
    check("t4_shl", {16'd0, plant}, 32'h000F);
    run_cmd(0, 3'd5, 4'd0, 16'h0000, 1'b1);
    check("t4_shr0", {16'd0, plant}, 32'h000F);

    // Test 5: asynchronous reset in the middle of INC x10
    run_cmd(0, 3'd2, 4'd0, 16'h0100, 1'b0);
    @(negedge clk);
    set_req(0, 1'b1, 3'd3, 4'd10, 16'h0, 1'b0);
    #1;
    check("t5_accept", {31'd0, req0_ready}, 1);
    @(posedge clk); #1;
    req0_valid = 1'b0;
    for (int k = 1; k <= 4; k++) begin
      @(negedge clk);
      check("t5_inc", {31'd0, reg_inc}, 1);
    end
    @(posedge clk); #2;
    rst_n = 1'b0;
    #1;
    check("t5_async_strobes", {26'd0, sv}, 0);
    check("t5_async_misc", {13'd0, reg_in, reg_ir, reg_il, busy, done, done_id}, 0);
    @(negedge clk);
    rst_n = 1'b1;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      check("t5_no_done", {30'd0, done, busy}, 0);
    end
    check("t5_value", {16'd0, plant}, 32'h0104);
    set_req(0, 1'b1, 3'd0, 4'd0, 16'h0, 1'b0);
    set_req(1, 1'b1, 3'd0, 4'd0, 16'h0, 1'b0);
    #1;
    check("t5_prio", {30'd0, req0_ready, req1_ready}, 2);
    @(posedge clk); #1;
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    repeat (4) @(negedge clk);

    // Test 6: DEC wrap and reserved op
    run_cmd(1, 3'd2, 4'd0, 16'h0000, 1'b0);
    run_cmd(0, 3'd4, 4'd2, 16'h0000, 1'b0);
    check("t6_dec", {16'd0, plant}, 32'hFFFE);
    run_cmd(1, 3'd7, 4'd9, 16'hABCD, 1'b1);
    check("t6_rsvd", {16'd0, plant}, 32'hFFFE);

    // Randomized commands
    for (int n = 0; n < 25; n++) begin
      run_cmd(int'($urandom_range(0, 1)), 3'($urandom_range(0, 7)),
              CW'($urandom_range(0, 15)), DW'($urandom), 1'($urandom_range(0, 1)));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, observed timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
